alarm_escalation_ctrl: RTL

//  Parametrised successor of the seat-alarm top controller. Synchronises the seat alarm request
//  and driver button, derives an internal tick from clk (replaces external clock delay),

---
 rtl/alarm_escalation_ctrl.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/alarm_escalation_ctrl.sv
// alarm_escalation_ctrl
//   Seat-alarm escalation controller. Synchronises the seat-link alarm request
//   and the driver acknowledge button, derives a slow tick from clk, and runs the
//   grace / escalation / silence sequence. The alarm outputs form a thermometer
//   code of the escalation level.
//
//   Optional build macro: ALARM_LED_BLINK_EN
//     undefined : led is the synchronised request, registered
//     defined   : led is 0 in IDLE/SILENCED, 1 in PENDING, blinks once per tick in ALARM
//
//   Ports
//     clk            system clock
//     rst_n          asynchronous active-low reset
//     communication  alarm request from the seat link (async, active-high)
//     button         driver acknowledge button (async, raw, active-high)
//     saida[N_OUT]   alarm outputs, saida[i]=1 when level>i
//     level          escalation level 0..N_OUT
//     state          00 IDLE, 01 PENDING, 10 ALARM, 11 SILENCED
//     led            status LED
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   IDLE     | no request, outputs off
//   PENDING  | request seen, grace period running, outputs off
//   ALARM    | outputs on, level steps up every STEP_TICKS ticks
//   SILENCED | acknowledged by driver, outputs off until re-arm or request drop

module alarm_escalation_ctrl #(
   parameter int N_OUT          = 3,
   parameter int PRESCALE       = 50000,
   parameter int DEBOUNCE_TICKS = 4,
   parameter int ALERT_TICKS    = 10,
   parameter int STEP_TICKS     = 20,
   parameter int REARM_TICKS    = 600
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       communication,
   input  logic                       button,
   output logic [N_OUT-1:0]           saida,
   output logic [$clog2(N_OUT+1)-1:0] level,
   output logic [1:0]                 state,
   output logic                       led
);

   localparam int LVL_W   = $clog2(N_OUT + 1);
   localparam int PRE_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int RUN_W   = $clog2(DEBOUNCE_TICKS + 1);
   localparam int TMR_MAX = (ALERT_TICKS > STEP_TICKS)
                            ? ((ALERT_TICKS > REARM_TICKS) ? ALERT_TICKS : REARM_TICKS)
                            : ((STEP_TICKS > REARM_TICKS) ? STEP_TICKS : REARM_TICKS);
   localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
   localparam logic [RUN_W-1:0] RUN_SAT  = RUN_W'(DEBOUNCE_TICKS);
   localparam logic [RUN_W-1:0] RUN_PRE  = RUN_W'(DEBOUNCE_TICKS - 1);
   localparam logic [TMR_W-1:0] ALERT_LD = TMR_W'(ALERT_TICKS - 1);
   localparam logic [TMR_W-1:0] STEP_LD  = TMR_W'(STEP_TICKS - 1);
   localparam logic [TMR_W-1:0] REARM_LD = TMR_W'(REARM_TICKS - 1);
   localparam logic [LVL_W-1:0] LVL_MAX  = LVL_W'(N_OUT);
   localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);

   typedef enum logic [1:0] {
      S_IDLE     = 2'b00,
      S_PENDING  = 2'b01,
      S_ALARM    = 2'b10,
      S_SILENCED = 2'b11
   } state_t;

   state_t           state_q;
   logic             comm_s1, comm_s2;
   logic             btn_s1, btn_s2;
   logic [PRE_W-1:0] pre_cnt;
   logic             tick;
   logic [RUN_W-1:0] run_cnt;
   logic             press;
   logic             req;
   logic [TMR_W-1:0] tmr;
   logic [LVL_W-1:0] level_up;

   function automatic logic [N_OUT-1:0] therm(input logic [LVL_W-1:0] l);
      logic [N_OUT-1:0] t;
      for (int i = 0; i < N_OUT; i++) t[i] = (int'(l) > i);
      return t;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         comm_s1 <= 1'b0;
         comm_s2 <= 1'b0;
         btn_s1  <= 1'b0;
         btn_s2  <= 1'b0;
      end else begin
         comm_s1 <= communication;
         comm_s2 <= comm_s1;
         btn_s1  <= button;
         btn_s2  <= btn_s1;
      end
   end

   assign req = comm_s2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    pre_cnt <= '0;
      else if (tick) pre_cnt <= '0;
      else           pre_cnt <= pre_cnt + 1'b1;
   end

   assign tick = (pre_cnt == PRE_LAST);

   // Run length saturates so a held button yields exactly one press.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_cnt <= '0;
      end else if (tick) begin
         if (!btn_s2)                run_cnt <= '0;
         else if (run_cnt != RUN_SAT) run_cnt <= run_cnt + 1'b1;
      end
   end

   assign press = tick && btn_s2 && (run_cnt == RUN_PRE);

   assign level_up = (level == LVL_MAX) ? level : level + 1'b1;

   // tmr is reloaded with period-1 on every state entry; expiry is the tick
   // that finds it at zero. In ALARM it reloads on each step and keeps running
   // after the level saturates.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         tmr     <= '0;
         level   <= '0;
         saida   <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req) begin
                  state_q <= S_PENDING;
                  tmr     <= ALERT_LD;
               end
            end
            S_PENDING: begin
               if (!req) begin
                  state_q <= S_IDLE;
                  tmr     <= '0;
               end else if (press) begin
                  state_q <= S_SILENCED;
                  tmr     <= REARM_LD;
               end else if (tick) begin
                  if (tmr == '0) begin
                     state_q <= S_ALARM;
                     tmr     <= STEP_LD;
                     level   <= LVL_ONE;
                     saida   <= therm(LVL_ONE);
                  end else begin
                     tmr <= tmr - 1'b1;
                  end
               end
            end
            S_ALARM: begin
               if (!req) begin
                  state_q <= S_IDLE;
                  tmr     <= '0;
                  level   <= '0;
                  saida   <= '0;
               end else if (press) begin
                  state_q <= S_SILENCED;
                  tmr     <= REARM_LD;
                  level   <= '0;
                  saida   <= '0;
               end else if (tick) begin
                  if (tmr == '0) begin
                     tmr   <= STEP_LD;
                     level <= level_up;
                     saida <= therm(level_up);
                  end else begin
                     tmr <= tmr - 1'b1;
                  end
               end
            end
            S_SILENCED: begin
               if (!req) begin
                  state_q <= S_IDLE;
                  tmr     <= '0;
               end else if (tick) begin
                  if (tmr == '0) begin
                     state_q <= S_PENDING;
                     tmr     <= ALERT_LD;
                  end else begin
                     tmr <= tmr - 1'b1;
                  end
               end
            end
            default: begin
               state_q <= S_IDLE;
               tmr     <= '0;
               level   <= '0;
               saida   <= '0;
            end
         endcase
      end
   end

   assign state = state_q;

`ifdef ALARM_LED_BLINK_EN
   // blink_off is held low outside ALARM so the LED is lit on ALARM entry.
   logic blink_off;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                   blink_off <= 1'b0;
      else if (state_q != S_ALARM) blink_off <= 1'b0;
      else if (tick)               blink_off <= ~blink_off;
   end

   assign led = (state_q == S_PENDING) || ((state_q == S_ALARM) && !blink_off);
`else
   logic led_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) led_q <= 1'b0;
      else        led_q <= comm_s2;
   end

   assign led = led_q;
`endif

endmodule
